// File: rtl/heartbeat_pkg.sv
// Shared types and constants for the heartbeat beat scheduler.
// Holds state encoding, LED patterns, rate formula constants and the 7-segment decoder.
package heartbeat_pkg;

   typedef enum logic [2:0] {
      ST_PAUSE = 3'd0,
      ST_BEAT1 = 3'd1,
      ST_GAP1  = 3'd2,
      ST_BEAT2 = 3'd3,
      ST_REST  = 3'd4
   } state_t;

   localparam logic [7:0] LED_BEAT1 = 8'hFF;
   localparam logic [7:0] LED_BEAT2 = 8'h3C;
   localparam logic [7:0] LED_PAUSE = 8'h80;
   localparam logic [7:0] LED_OFF   = 8'h00;

   // period_ms = RATE_BASE_MS - RATE_STEP_MS * sw
   localparam int RATE_BASE_MS = 1000;
   localparam int RATE_STEP_MS = 40;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'h3F;
         4'd1:    seg7 = 7'h06;
         4'd2:    seg7 = 7'h5B;
         4'd3:    seg7 = 7'h4F;
         4'd4:    seg7 = 7'h66;
         4'd5:    seg7 = 7'h6D;
         4'd6:    seg7 = 7'h7D;
         4'd7:    seg7 = 7'h07;
         4'd8:    seg7 = 7'h7F;
         4'd9:    seg7 = 7'h6F;
         default: seg7 = 7'h00;
      endcase
   endfunction

   function automatic logic [7:0] led_pattern(input state_t s);
      case (s)
         ST_BEAT1: led_pattern = LED_BEAT1;
         ST_BEAT2: led_pattern = LED_BEAT2;
         ST_PAUSE: led_pattern = LED_PAUSE;
         default:  led_pattern = LED_OFF;
      endcase
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus tick-based debouncer for one active-low key.
// press is a one-cycle pulse on an accepted released-to-pressed (1->0) transition.
module key_debounce #(
   parameter int DEBOUNCE_MS = 20
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic key_n,
   output logic level,
   output logic press
);

   logic       r_s1;
   logic       r_s2;
   logic       r_level;
   logic       r_press;
   logic [7:0] r_cnt;

   // Any cycle where the synchronised input agrees with the level restarts the run.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1    <= 1'b1;
         r_s2    <= 1'b1;
         r_level <= 1'b1;
         r_press <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_s1    <= key_n;
         r_s2    <= r_s1;
         r_press <= 1'b0;
         if (r_s2 == r_level) begin
            r_cnt <= '0;
         end else if (tick) begin
            if (r_cnt == 8'(DEBOUNCE_MS - 1)) begin
               r_level <= r_s2;
               r_cnt   <= '0;
               r_press <= r_level;
            end else begin
               r_cnt <= r_cnt + 8'd1;
            end
         end
      end
   end

   assign level = r_level;
   assign press = r_press;

endmodule

// File: rtl/heartbeat_sched.sv
// Lub-dub beat scheduler: prescaler, key handling, beat FSM, BCD beat counter
// and registered LED / 7-segment outputs.
module heartbeat_sched
   import heartbeat_pkg::*;
#(
   parameter int TICK_DIV    = 12000,
   parameter int DEBOUNCE_MS = 20,
   parameter int BEAT_MS     = 100
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] sw_input,
   input  logic [3:0] key_input,
   output logic [7:0] led,
   output logic [8:0] seg1,
   output logic [8:0] seg2,
   output logic [2:0] o_dbg_state
);

   logic [15:0] r_pre;
   logic        w_tick;
   logic [3:0]  w_level;
   logic [3:0]  w_press;
   logic        w_unused;

   state_t      r_state;
   logic [15:0] r_ms_cnt;
   logic [15:0] r_rest_ms;
   logic        r_running;
   logic        r_pend_run;
   logic        r_pend_step;
   logic [7:0]  r_led;
   logic [3:0]  r_tens;
   logic [3:0]  r_units;
   logic [8:0]  r_seg1;
   logic [8:0]  r_seg2;

   logic        w_end;
   logic        w_run_now;
   logic        w_start;
   logic        w_loop;
   logic        w_enter_beat1;
   logic [15:0] w_rest_new;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)         r_pre <= '0;
      else if (w_tick) r_pre <= '0;
      else             r_pre <= r_pre + 16'd1;
   end
   assign w_tick = (r_pre == 16'(TICK_DIV - 1));

   for (genvar g = 0; g < 4; g++) begin : g_key
      key_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_deb (
         .clk   (clk),
         .rst   (rst),
         .tick  (w_tick),
         .key_n (key_input[g]),
         .level (w_level[g]),
         .press (w_press[g])
      );
   end
   assign w_unused = ^{w_level, w_press[3]};

   // A key0 press in the same cycle as the end of REST already counts as a pause request.
   always_comb begin
      w_end         = (r_state == ST_REST) ? (r_ms_cnt == r_rest_ms - 16'd1)
                                           : (r_ms_cnt == 16'(BEAT_MS - 1));
      w_run_now     = r_running & ~w_press[0];
      w_start       = (r_state == ST_PAUSE) & w_tick & (r_pend_run | r_pend_step);
      w_loop        = (r_state == ST_REST) & w_tick & w_end & w_run_now;
      w_enter_beat1 = w_start | w_loop;
      w_rest_new    = 16'(RATE_BASE_MS - RATE_STEP_MS * int'(sw_input) - 3 * BEAT_MS);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_PAUSE;
         r_ms_cnt    <= '0;
         r_rest_ms   <= '0;
         r_running   <= 1'b0;
         r_pend_run  <= 1'b0;
         r_pend_step <= 1'b0;
         r_led       <= LED_PAUSE;
      end else begin
         r_led <= led_pattern(r_state);
         case (r_state)
            ST_PAUSE: begin
               if (w_press[0]) r_pend_run  <= 1'b1;
               if (w_press[2]) r_pend_step <= 1'b1;
               if (w_start) begin
                  r_state     <= ST_BEAT1;
                  r_ms_cnt    <= '0;
                  r_running   <= r_pend_run | w_press[0];
                  r_pend_run  <= 1'b0;
                  r_pend_step <= 1'b0;
               end
            end
            default: begin
               if (w_press[0]) r_running <= 1'b0;
               if (w_tick) begin
                  if (w_end) begin
                     r_ms_cnt <= '0;
                     case (r_state)
                        ST_BEAT1: r_state <= ST_GAP1;
                        ST_GAP1:  r_state <= ST_BEAT2;
                        ST_BEAT2: begin
                           r_state   <= ST_REST;
                           r_rest_ms <= w_rest_new;
                        end
                        default:  r_state <= w_run_now ? ST_BEAT1 : ST_PAUSE;
                     endcase
                  end else begin
                     r_ms_cnt <= r_ms_cnt + 16'd1;
                  end
               end
            end
         endcase
      end
   end

   // Clear has priority over the increment that accompanies a BEAT1 entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tens  <= '0;
         r_units <= '0;
      end else if (w_press[1]) begin
         r_tens  <= '0;
         r_units <= '0;
      end else if (w_enter_beat1) begin
         if (r_units == 4'd9) begin
            r_units <= '0;
            r_tens  <= (r_tens == 4'd9) ? 4'd0 : r_tens + 4'd1;
         end else begin
            r_units <= r_units + 4'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_seg1 <= 9'h03F;
         r_seg2 <= 9'h03F;
      end else begin
         r_seg1 <= {2'b00, seg7(r_tens)};
         r_seg2 <= {2'b00, seg7(r_units)};
      end
   end

   assign led         = r_led;
   assign seg1        = r_seg1;
   assign seg2        = r_seg2;
   assign o_dbg_state = r_state;

endmodule
